param_delay_pipe: RTL and testbench

- Parameterised DEPTH-stage, WIDTH-bit registered delay pipeline with valid/ready handshake on both sides.
- Every data register resets to INIT.
- Sits directly downstream of the constant/parameter source blocks in the defparam regression suite. It consumes their WIDTH-bit value and exercises WIDTH/DEPTH/INIT overrides, applied by defparam or #(), on real sequential state.
- Self-checking benches drive it and compare against expected latency and values.

---
 rtl/param_delay_pipe_pkg.sv | 20 ++
 rtl/param_pipe_stage.sv | 30 +++
 rtl/param_delay_pipe.sv | 80 ++++++++
 tb/tb_param_delay_pipe.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_delay_pipe_pkg.sv
// Shared constants and helpers for the parameterised delay pipeline.
// Benches use the legal-range limits when sweeping parameters.
package param_delay_pipe_pkg;

  localparam int unsigned WIDTH_MAX = 64;
  localparam int unsigned DEPTH_MAX = 16;

  // Ceiling log2; callers pass DEPTH+1, so n is always at least 2.
  function automatic int unsigned pdp_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned CW_MAX = pdp_clog2(DEPTH_MAX + 1);

endpackage

// File: rtl/param_pipe_stage.sv
// One pipeline slot: WIDTH-bit data register plus valid bit.
// The slot loads on enable and returns to INIT on reset or flush.
module param_pipe_stage #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             en,
  input  logic [WIDTH-1:0] d_in,
  input  logic             v_in,
  output logic [WIDTH-1:0] d_q,
  output logic             v_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= INIT;
      v_q <= 1'b0;
    end else if (flush) begin
      d_q <= INIT;
      v_q <= 1'b0;
    end else if (en) begin
      d_q <= d_in;
      v_q <= v_in;
    end
  end

endmodule

// File: rtl/param_delay_pipe.sv
// DEPTH-stage registered delay line with valid/ready on both ends.
// A stall freezes every stage; there is no bubble collapsing.
module param_delay_pipe
  import param_delay_pipe_pkg::*;
#(
  parameter int unsigned          WIDTH = 4,
  parameter int unsigned          DEPTH = 2,
  parameter logic [WIDTH_MAX-1:0] INIT  = '0,
  localparam int unsigned         CW    = pdp_clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  localparam logic [WIDTH-1:0] INIT_W = INIT[WIDTH-1:0];

  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] v;
  logic             adv;
  logic             acc;
  logic             leave;

  // Whole line moves together whenever the tail is empty or being drained.
  assign adv      = !v[DEPTH-1] || out_ready;
  assign in_ready = adv;
  assign acc      = in_valid && adv;
  assign leave    = v[DEPTH-1] && out_ready;

  assign out_data  = d[DEPTH-1];
  assign out_valid = v[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic             v_in;

    if (i == 0) begin : g_head
      assign d_in = in_data;
      assign v_in = in_valid;
    end else begin : g_body
      assign d_in = d[i-1];
      assign v_in = v[i-1];
    end

    param_pipe_stage #(
      .WIDTH (WIDTH),
      .INIT  (INIT_W)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .en    (adv),
      .d_in  (d_in),
      .v_in  (v_in),
      .d_q   (d[i]),
      .v_q   (v[i])
    );
  end

  // Occupancy tracks accepts minus departures; flush drops everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (acc && !leave) begin
      count <= count + CW'(1);
    end else if (leave && !acc) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_param_delay_pipe.sv
// Bench for param_delay_pipe: five differently parameterised copies share one
// stimulus stream and are compared against a queue model of a fixed-length line.
module tb_param_delay_pipe;
  import param_delay_pipe_pkg::*;

  localparam int unsigned NI = 5;
  localparam int unsigned DEPS  [NI] = '{4, 2, 1, 4, 16};
  localparam int unsigned WIDS  [NI] = '{8, 8, 1, 8, 64};
  localparam logic [63:0] INITS [NI] = '{64'hAB, 64'h0, 64'h1, 64'hCD, 64'hFFFF_0000_1234_5678};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 flush;
  logic                 in_valid;
  logic                 out_ready;
  logic [WIDTH_MAX-1:0] in_data;

  logic       a_rdy, a_ov;
  logic [7:0] a_od;
  logic [2:0] a_cnt;
  logic       b_rdy, b_ov;
  logic [7:0] b_od;
  logic [1:0] b_cnt;
  logic       s1_rdy, s1_ov, s1_od, s1_cnt;
  logic       s2_rdy, s2_ov;
  logic [7:0] s2_od;
  logic [2:0] s2_cnt;
  logic        s3_rdy, s3_ov;
  logic [63:0] s3_od;
  logic [4:0]  s3_cnt;

  param_delay_pipe u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_rdy),
    .in_data(in_data[7:0]), .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od), .count(a_cnt)
  );
  defparam u_a.WIDTH = 8;
  defparam u_a.DEPTH = 4;
  defparam u_a.INIT  = 64'hAB;

  param_delay_pipe #(.WIDTH(8), .DEPTH(2), .INIT(64'h0)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_rdy),
    .in_data(in_data[7:0]), .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od), .count(b_cnt)
  );

  param_delay_pipe u_s1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s1_rdy),
    .in_data(in_data[0:0]), .out_valid(s1_ov), .out_ready(out_ready), .out_data(s1_od), .count(s1_cnt)
  );
  defparam u_s1.WIDTH = 1;
  defparam u_s1.DEPTH = 1;
  defparam u_s1.INIT  = 64'h1;

  param_delay_pipe u_s2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s2_rdy),
    .in_data(in_data[7:0]), .out_valid(s2_ov), .out_ready(out_ready), .out_data(s2_od), .count(s2_cnt)
  );
  defparam u_s2.WIDTH = 8;
  defparam u_s2.DEPTH = 4;
  defparam u_s2.INIT  = 64'hCD;

  param_delay_pipe u_s3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s3_rdy),
    .in_data(in_data), .out_valid(s3_ov), .out_ready(out_ready), .out_data(s3_od), .count(s3_cnt)
  );
  defparam u_s3.WIDTH = 64;
  defparam u_s3.DEPTH = 16;
  defparam u_s3.INIT  = 64'hFFFF_0000_1234_5678;

  logic [63:0] ob_d [NI];
  logic        ob_v [NI];
  logic        ob_r [NI];
  logic [7:0]  ob_c [NI];

  assign ob_d[0] = 64'(a_od);  assign ob_v[0] = a_ov;  assign ob_r[0] = a_rdy;  assign ob_c[0] = 8'(a_cnt);
  assign ob_d[1] = 64'(b_od);  assign ob_v[1] = b_ov;  assign ob_r[1] = b_rdy;  assign ob_c[1] = 8'(b_cnt);
  assign ob_d[2] = 64'(s1_od); assign ob_v[2] = s1_ov; assign ob_r[2] = s1_rdy; assign ob_c[2] = 8'(s1_cnt);
  assign ob_d[3] = 64'(s2_od); assign ob_v[3] = s2_ov; assign ob_r[3] = s2_rdy; assign ob_c[3] = 8'(s2_cnt);
  assign ob_d[4] = s3_od;      assign ob_v[4] = s3_ov; assign ob_r[4] = s3_rdy; assign ob_c[4] = 8'(s3_cnt);

  // Model: each copy is a fixed-length queue; front is the input end, back is the output.
  typedef struct packed {
    logic        v;
    logic [63:0] d;
  } ent_t;

  ent_t        mq [NI][$];
  logic [63:0] emit_b [$];
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [63:0] wmask(input int unsigned w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  task automatic m_reset_one(input int k);
    ent_t e;
    e.v = 1'b0;
    e.d = INITS[k] & wmask(WIDS[k]);
    mq[k].delete();
    for (int i = 0; i < int'(DEPS[k]); i++) mq[k].push_back(e);
  endtask

  task automatic m_reset_all();
    for (int k = 0; k < int'(NI); k++) m_reset_one(k);
  endtask

  function automatic ent_t m_tail(input int k);
    return mq[k][mq[k].size() - 1];
  endfunction

  function automatic int m_count(input int k);
    int n = 0;
    for (int i = 0; i < mq[k].size(); i++) if (mq[k][i].v) n++;
    return n;
  endfunction

  task automatic m_edge();
    ent_t e;
    for (int k = 0; k < int'(NI); k++) begin
      if (rst || flush) begin
        m_reset_one(k);
      end else if (!m_tail(k).v || out_ready) begin
        void'(mq[k].pop_back());
        e.v = in_valid;
        e.d = in_data & wmask(WIDS[k]);
        mq[k].push_front(e);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    ent_t t;
    for (int k = 0; k < int'(NI); k++) begin
      t = m_tail(k);
      chk($sformatf("%s u%0d out_valid", tag, k), 64'(ob_v[k]), 64'(t.v));
      chk($sformatf("%s u%0d in_ready", tag, k), 64'(ob_r[k]), 64'(!t.v || out_ready));
      chk($sformatf("%s u%0d count", tag, k), 64'(ob_c[k]), 64'(m_count(k)));
      if (t.v) chk($sformatf("%s u%0d out_data", tag, k), ob_d[k], t.d);
    end
  endtask

  task automatic step(input string tag);
    if (ob_v[1] && out_ready) emit_b.push_back(ob_d[1]);
    @(posedge clk);
    m_edge();
    #1;
    check_all(tag);
  endtask

  // Push one word into empty pipelines and measure edges until it appears at each output.
  task automatic lat_probe(input string tag, input logic [63:0] word);
    int first [NI];
    for (int k = 0; k < int'(NI); k++) first[k] = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = word;
    for (int n = 1; n <= 40; n++) begin
      step(tag);
      if (n == 1) in_valid = 1'b0;
      for (int k = 0; k < int'(NI); k++) begin
        if (first[k] == 0 && ob_v[k]) begin
          first[k] = n;
          chk($sformatf("%s u%0d word", tag, k), ob_d[k], word & wmask(WIDS[k]));
        end
      end
    end
    for (int k = 0; k < int'(NI); k++)
      chk($sformatf("%s u%0d latency", tag, k), 64'(first[k]), 64'(DEPS[k]));
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    m_reset_all();
    #1;
    chk("reset a out_data", 64'(a_od), 64'hAB);
    chk("reset a out_valid", 64'(a_ov), 64'h0);
    chk("reset a in_ready", 64'(a_rdy), 64'h1);
    chk("reset a count", 64'(a_cnt), 64'h0);
    chk("reset s1 out_data", 64'(s1_od), 64'h1);
    chk("reset s2 out_data", 64'(s2_od), 64'hCD);
    chk("reset s3 out_data", s3_od, 64'hFFFF_0000_1234_5678);
    check_all("reset");
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) step("idle");

    // Back-to-back stream through DEPTH=4
    for (int j = 1; j <= 11; j++) begin
      in_valid = (j <= 8);
      in_data  = 64'(j);
      step("stream");
      if (j >= 4) begin
        chk("stream a out_valid", 64'(a_ov), 64'h1);
        chk("stream a out_data", 64'(a_od), 64'(j - 3));
      end
      if (j >= 4 && j <= 8) chk("stream a count", 64'(a_cnt), 64'h4);
    end
    in_valid = 1'b0;
    repeat (16) step("drain1");

    // Backpressure on DEPTH=2
    emit_b.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hC1;
    step("bp_fill");
    in_data = 64'hC2;
    step("bp_fill");
    chk("bp b count full", 64'(b_cnt), 64'h2);
    chk("bp b in_ready full", 64'(b_rdy), 64'h0);
    in_data = 64'h33;
    repeat (3) step("bp_hold");
    chk("bp b count held", 64'(b_cnt), 64'h2);
    chk("bp b out_data held", 64'(b_od), 64'hC1);
    out_ready = 1'b1;
    step("bp_release");
    in_valid = 1'b0;
    repeat (4) step("bp_drain");
    chk("bp b emitted", 64'(emit_b.size()), 64'h3);
    if (emit_b.size() == 3) begin
      chk("bp b first", emit_b[0], 64'hC1);
      chk("bp b second", emit_b[1], 64'hC2);
      chk("bp b third", emit_b[2], 64'h33);
    end
    repeat (20) step("drain2");

    // Flush with three words in flight and a simultaneous accept
    in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_data = 64'hA1 + 64'(j);
      step("fl_fill");
    end
    chk("fl a count", 64'(a_cnt), 64'h3);
    flush   = 1'b1;
    in_data = 64'hF4;
    step("flush");
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl a out_valid", 64'(a_ov), 64'h0);
    chk("fl a count zero", 64'(a_cnt), 64'h0);
    chk("fl a out_data init", 64'(a_od), 64'hAB);
    for (int j = 0; j < 6; j++) begin
      step("fl_after");
      chk("fl a nothing emerges", 64'(a_ov), 64'h0);
    end

    // Asynchronous reset between edges with three words in flight
    in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_data = 64'h11 * 64'(j + 1);
      step("ar_fill");
    end
    in_valid = 1'b0;
    chk("ar a count", 64'(a_cnt), 64'h3);
    #2;
    rst = 1'b1;
    m_reset_all();
    #1;
    chk("ar a out_valid", 64'(a_ov), 64'h0);
    chk("ar a out_data", 64'(a_od), 64'hAB);
    chk("ar a count", 64'(a_cnt), 64'h0);
    check_all("async_rst");
    rst = 1'b0;
    lat_probe("ar_cd", 64'hCD);

    // Fill every copy to capacity, then flush and probe latency with a wide word
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int j = 0; j < 20; j++) begin
      in_data = {$urandom, $urandom};
      step("sw_fill");
    end
    chk("sw s3 count full", 64'(s3_cnt), 64'd16);
    chk("sw s3 in_ready full", 64'(s3_rdy), 64'h0);
    chk("sw s1 count full", 64'(s1_cnt), 64'h1);
    flush = 1'b1;
    step("sw_flush");
    flush = 1'b0;
    lat_probe("sweep", 64'hDEAD_BEEF_0BAD_F00D);

    // Random traffic with occasional flush
    for (int j = 0; j < 400; j++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      in_data   = {$urandom, $urandom};
      flush     = 1'($urandom_range(0, 40) == 0);
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
